// File: rtl/intdiv_ctrl_pkg.sv
// intdiv_ctrl_pkg: shared layout of the result entries carried from the tag pipe
// through the output FIFO. An entry is {z[N], r[N], ovf, dbz}, LSB first from the
// flags, so the entry width is 2N+2 for any operand width N.
package intdiv_ctrl_pkg;

  localparam int DBZ_BIT = 0;  // entry bit: result came from a divide by zero
  localparam int OVF_BIT = 1;  // entry bit: result came from MIN/-1 overflow
  localparam int FLAG_W  = 2;  // flag bits below the remainder field

  // Width of one result entry for an N-bit divider.
  function automatic int entry_width(input int n);
    return 2 * n + FLAG_W;
  endfunction

endpackage

// File: rtl/intdiv_ctrl_fifo.sv
// intdiv_ctrl_fifo: synchronous FIFO whose head is held in a register.
// Latency: a push into an empty FIFO is visible on head_* after the same edge.
// Backpressure: pop is honoured only while head_valid; push when full is not guarded.
// Ports: clock/reset_n (async active-low), push/push_data (write side),
//        pop (consume head), head_valid/head_data (registered head), count (entries held).
// head_data keeps its last value while the FIFO is empty and is 0 out of reset.
module intdiv_ctrl_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_kept;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_ok;

  always_comb begin
    pop_ok     = pop && head_valid;
    rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_kept = count - CW'(pop_ok);
    count_nxt  = count_kept + CW'(push);
    // With nothing left after the pop, the incoming entry becomes the head
    // directly; its memory slot is only written at this same edge.
    head_nxt   = (count_kept == '0) ? push_data : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        head_data <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/intdiv_ctrl.sv
// intdiv_ctrl: valid/ready wrapper around the non-stalling pipelined signed divider core.
// Latency: accept at edge k -> out_valid after edge k+DIV_LAT+1 (FIFO empty), in order.
// Backpressure: credit-based; in_ready only while FIFO entries + in-flight tags < DEPTH.
// Ports: clock/reset_n (async active-low); in_valid/in_ready/in_x/in_y operand side;
//        div_x/div_y to the core, div_z/div_r from its registered outputs;
//        out_valid/out_ready/out_z/out_r/out_dbz/out_ovf result side (FIFO head).
module intdiv_ctrl
  import intdiv_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int DIV_LAT = 4,
  parameter int DEPTH   = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  output logic [N-1:0] div_x,
  output logic [N-1:0] div_y,
  input  logic [N-1:0] div_z,
  input  logic [N-1:0] div_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic [N-1:0] out_r,
  output logic         out_dbz,
  output logic         out_ovf
);

  localparam int EW  = entry_width(N);
  localparam int RL  = FLAG_W;
  localparam int ZL  = FLAG_W + N;
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int CW  = $clog2(DEPTH + DIV_LAT + 1) + 1;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE     = N'(1);

  logic           ready_en;
  logic           accept;
  logic           is_dbz;
  logic           is_ovf;
  logic [N-1:0]   spc_z;
  logic [N-1:0]   spc_r;
  logic [CW-1:0]  inflight;
  logic [FCW-1:0] fifo_count;
  logic [EW-1:0]  push_data;
  logic [EW-1:0]  head_data;
  logic           head_valid;
  logic           pop;

  // Tag stage 0 is captured on the accept edge, the same edge the core samples
  // x/y; stage DIV_LAT lines up with the core's registered z/r for that operation.
  logic [DIV_LAT:0] tag_vld;
  logic [DIV_LAT:0] tag_dbz;
  logic [DIV_LAT:0] tag_ovf;
  logic [N-1:0]     tag_z [DIV_LAT+1];
  logic [N-1:0]     tag_r [DIV_LAT+1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= DIV_LAT; i++) begin
      inflight = inflight + CW'(tag_vld[i]);
    end
    // Registered state only: a pop this cycle frees its credit next cycle.
    in_ready = ready_en && ((CW'(fifo_count) + inflight) < CW'(DEPTH));
    accept   = in_valid && in_ready;

    is_dbz   = (in_y == '0);
    is_ovf   = !is_dbz && (in_x == MIN_VAL) && (in_y == {N{1'b1}});
    spc_z    = is_dbz ? {N{1'b1}} : in_x;
    spc_r    = is_dbz ? in_x : '0;

    // Special cases never reach the core, so it cannot be handed y == 0.
    div_x = '0;
    div_y = ONE;
    if (accept && !is_dbz && !is_ovf) begin
      div_x = in_x;
      div_y = in_y;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      tag_vld  <= '0;
      tag_dbz  <= '0;
      tag_ovf  <= '0;
      for (int i = 0; i <= DIV_LAT; i++) begin
        tag_z[i] <= '0;
        tag_r[i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      tag_vld  <= {tag_vld[DIV_LAT-1:0], accept};
      tag_dbz  <= {tag_dbz[DIV_LAT-1:0], accept && is_dbz};
      tag_ovf  <= {tag_ovf[DIV_LAT-1:0], accept && is_ovf};
      tag_z[0] <= spc_z;
      tag_r[0] <= spc_r;
      for (int i = 1; i <= DIV_LAT; i++) begin
        tag_z[i] <= tag_z[i-1];
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  always_comb begin
    push_data = '0;
    if (tag_dbz[DIV_LAT] || tag_ovf[DIV_LAT]) begin
      push_data[ZL +: N]  = tag_z[DIV_LAT];
      push_data[RL +: N]  = tag_r[DIV_LAT];
      push_data[DBZ_BIT]  = tag_dbz[DIV_LAT];
      push_data[OVF_BIT]  = tag_ovf[DIV_LAT];
    end else begin
      push_data[ZL +: N]  = div_z;
      push_data[RL +: N]  = div_r;
    end
    pop = head_valid && out_ready;
  end

  intdiv_ctrl_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (tag_vld[DIV_LAT]),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  always_comb begin
    out_valid = head_valid;
    out_z     = head_data[ZL +: N];
    out_r     = head_data[RL +: N];
    out_dbz   = head_data[DBZ_BIT];
    out_ovf   = head_data[OVF_BIT];
  end

endmodule

// File: tb/tb_intdiv_ctrl.sv
// tb_intdiv_ctrl: directed vectors for intdiv_ctrl (N=4, DIV_LAT=4, DEPTH=4) with a
// behavioural pipelined divider standing in for the core: it samples div_x/div_y
// on an edge and presents z/r DIV_LAT edges later, for one cycle.
module tb_intdiv_ctrl;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic [3:0] div_x;
  logic [3:0] div_y;
  logic [3:0] div_z;
  logic [3:0] div_r;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_z;
  logic [3:0] out_r;
  logic       out_dbz;
  logic       out_ovf;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] dx;   // expected div_x on the accept cycle
    logic [3:0] dy;   // expected div_y on the accept cycle
    logic [3:0] z;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];
  vec_t one_one;

  intdiv_ctrl #(.N(4), .DIV_LAT(4), .DEPTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_z     (div_z),
    .div_r     (div_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_r     (out_r),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core stand-in: five register stages, so the result is valid after edge k+4.
  logic signed [3:0] cz [5];
  logic signed [3:0] cr [5];
  always @(posedge clock) begin
    if (div_y == 4'd0) begin
      cz[0] <= 4'sd0;
      cr[0] <= 4'sd0;
    end else begin
      cz[0] <= $signed(div_x) / $signed(div_y);
      cr[0] <= $signed(div_x) % $signed(div_y);
    end
    for (int i = 1; i < 5; i++) begin
      cz[i] <= cz[i-1];
      cr[i] <= cr[i-1];
    end
  end
  assign div_z = cz[4];
  assign div_r = cr[4];

  // Flags any push into a full FIFO that is not matched by a pop.
  logic ovf_seen = 1'b0;
  always @(posedge clock) begin
    if (reset_n && dut.u_fifo.push && !(dut.u_fifo.pop && dut.u_fifo.head_valid) &&
        dut.u_fifo.count == 3'd4) begin
      ovf_seen <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One isolated operation: accept at edge k, result seen after edge k+5, popped at k+6.
  task automatic run_one(input vec_t v, input string tag);
    in_x      = v.x;
    in_y      = v.y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_div_x"}, 32'(div_x), 32'(v.dx));
    chk({tag, "_div_y"}, 32'(div_y), 32'(v.dy));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk({tag, "_not_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_z"}, 32'(out_z), 32'(v.z));
    chk({tag, "_r"}, 32'(out_r), 32'(v.r));
    chk({tag, "_dbz"}, 32'(out_dbz), 32'(v.dbz));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
    tick();
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_z_hold"}, 32'(out_z), 32'(v.z));
  endtask

  logic rdy_s;
  int   acc;
  int   stale;

  initial begin
    //            x      y      dx     dy     z      r      dbz   ovf
    vecs[0] = '{4'h7, 4'h3, 4'h7, 4'h3, 4'h2, 4'h1, 1'b0, 1'b0};  //  7 /  3
    vecs[1] = '{4'h8, 4'h3, 4'h8, 4'h3, 4'hE, 4'hE, 1'b0, 1'b0};  // -8 /  3
    vecs[2] = '{4'h9, 4'h2, 4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};  // -7 /  2
    vecs[3] = '{4'h6, 4'hC, 4'h6, 4'hC, 4'hF, 4'h2, 1'b0, 1'b0};  //  6 / -4
    vecs[4] = '{4'h5, 4'h0, 4'h0, 4'h1, 4'hF, 4'h5, 1'b1, 1'b0};  //  5 /  0
    vecs[5] = '{4'h8, 4'hF, 4'h0, 4'h1, 4'h8, 4'h0, 1'b0, 1'b1};  // -8 / -1
    vecs[6] = '{4'h8, 4'h0, 4'h0, 4'h1, 4'hF, 4'h8, 1'b1, 1'b0};  // -8 /  0
    vecs[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0};  // -1 / -1
    vecs[8] = '{4'h7, 4'hF, 4'h7, 4'hF, 4'h9, 4'h0, 1'b0, 1'b0};  //  7 / -1
    vecs[9] = '{4'hB, 4'h4, 4'hB, 4'h4, 4'hF, 4'hF, 1'b0, 1'b0};  // -5 /  4
    one_one = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_x      = 4'h0;
    in_y      = 4'h0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_flags", 32'({out_dbz, out_ovf}), 32'd0);
    chk("idle_div_x", 32'(div_x), 32'd0);
    chk("idle_div_y", 32'(div_y), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back: three accepts on consecutive edges, results on consecutive cycles.
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      in_x     = vecs[i].x;
      in_y     = vecs[i].y;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_z", i), 32'(out_z), 32'(vecs[i].z));
      chk($sformatf("b2b%0d_r", i), 32'(out_r), 32'(vecs[i].r));
    end
    tick();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Backpressure: consumer stalled, producer always offering.
    out_ready = 1'b0;
    acc       = 0;
    in_x      = vecs[0].x;
    in_y      = vecs[0].y;
    in_valid  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      rdy_s = in_ready;
      tick();
      if (rdy_s) begin
        acc++;
        if (acc < 4) begin
          in_x = vecs[acc].x;
          in_y = vecs[acc].y;
        end
      end
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_head_valid", 32'(out_valid), 32'd1);
    chk("bp_head_z", 32'(out_z), 32'(vecs[0].z));
    tick();
    chk("bp_head_stable_z", 32'(out_z), 32'(vecs[0].z));
    chk("bp_head_stable_r", 32'(out_r), 32'(vecs[0].r));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle_credit", 32'(in_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      if (i == 1) begin
        chk("bp_credit_back", 32'(in_ready), 32'd1);
      end
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_z", i), 32'(out_z), 32'(vecs[i].z));
      chk($sformatf("bp%0d_r", i), 32'(out_r), 32'(vecs[i].r));
    end
    tick();
    chk("bp_no_duplicate", 32'(out_valid), 32'd0);

    // Reset with one result queued and two still in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_x     = vecs[i].x;
      in_y     = vecs[i].y;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_z", 32'(out_z), 32'd0);
    tick();
    tick();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_release_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    run_one(one_one, "post_rst");

    chk("no_fifo_overflow", 32'(ovf_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
